fetch_request_unit: RTL and testbench

FETCH_REQUEST_UNIT -- requirements
Module: fetch_request_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buffer.sv | 35 +++
 rtl/fetch_request_unit.sv | 119 +++++++++++
 tb/tb_fetch_request_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared NOP encoding, next-PC select encodings and fetch FSM states
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JAL    = 2'b10,
        SEL_JALR   = 2'b11
    } next_pc_sel_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DROP = 2'b10
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {PC, instruction} holding register with a full flag
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    unload,
    input  logic [ADDRESS_BITS-1:0] load_pc,
    input  logic [DATA_WIDTH-1:0]   load_instr,
    output logic                    full,
    output logic [ADDRESS_BITS-1:0] pc,
    output logic [DATA_WIDTH-1:0]   instr
);
    // park a response on load, drop it on clear or when it moves downstream
    always_ff @(posedge clock) begin
        if (reset) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= DATA_WIDTH'(NOP_INSTR);
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (unload) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_request_unit.sv
// fetch_request_unit: issues single-outstanding icache reads and registers responses; FETCH_SKID_BUFFER_EN adds a one-entry skid
module fetch_request_unit
    import fetch_pkg::*;
#(
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [1:0]              next_PC_select_execute,
    input  logic                    branch_execute,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic                    icache_ready,
    output logic                    icache_read,
    output logic [ADDRESS_BITS-1:0] icache_address,
    input  logic                    icache_valid_in,
    input  logic [DATA_WIDTH-1:0]   icache_data,
    output logic [ADDRESS_BITS-1:0] inst_PC_fetch,
    output logic [DATA_WIDTH-1:0]   instruction_fetch,
    output logic                    fetch_valid
);
    fetch_state_t            state, state_next;
    next_pc_sel_t            sel;
    logic [ADDRESS_BITS-1:0] pc, target;
    logic                    redirect, response, slot_free, park;

    assign sel            = next_pc_sel_t'(next_PC_select_execute);
    assign redirect       = (sel == SEL_JAL) || (sel == SEL_JALR) || (sel == SEL_BRANCH && branch_execute);
    assign target         = (sel == SEL_JAL) ? JAL_target : (sel == SEL_JALR) ? JALR_target : branch_target;
    assign response       = (state == S_WAIT) && icache_valid_in && !redirect;
    assign icache_address = pc;

`ifdef FETCH_SKID_BUFFER_EN
    logic                    skid_full, unload;
    logic [ADDRESS_BITS-1:0] skid_pc;
    logic [DATA_WIDTH-1:0]   skid_instr;

    assign slot_free = !skid_full;
    assign park      = response && fetch_valid && stall;
    assign unload    = skid_full && !stall && !redirect;

    fetch_skid_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDRESS_BITS(ADDRESS_BITS)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect),
        .load      (park),
        .unload    (unload),
        .load_pc   (pc),
        .load_instr(icache_data),
        .full      (skid_full),
        .pc        (skid_pc),
        .instr     (skid_instr)
    );
`else
    // without a skid, a response always lands in the output register, which is free by then
    assign slot_free = !fetch_valid || !stall;
    assign park      = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        state <= reset ? S_IDLE : state_next;
    end

    // request strobe and next state; a response coinciding with a redirect is simply dropped
    always_comb begin
        state_next  = state;
        icache_read = 1'b0;
        case (state)
            S_IDLE: begin
                icache_read = !reset && icache_ready && !redirect && slot_free;
                state_next  = icache_read ? S_WAIT : S_IDLE;
            end
            S_WAIT:  state_next = icache_valid_in ? S_IDLE : redirect ? S_DROP : S_WAIT;
            S_DROP:  state_next = icache_valid_in ? S_IDLE : S_DROP;
            default: state_next = S_IDLE;
        endcase
    end

    // program counter: redirect wins, otherwise advance once per accepted response
    always_ff @(posedge clock) begin
        if (reset)
            pc <= RESET_PC;
        else if (redirect)
            pc <= target;
        else if (response)
            pc <= pc + ADDRESS_BITS'(4);
    end

    // fetch/decode output register: redirect flushes, stall holds, otherwise valid lasts one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            inst_PC_fetch     <= '0;
            instruction_fetch <= DATA_WIDTH'(NOP_INSTR);
            fetch_valid       <= 1'b0;
        end else if (redirect) begin
            fetch_valid <= 1'b0;
        end else if (response && !park) begin
            inst_PC_fetch     <= pc;
            instruction_fetch <= icache_data;
            fetch_valid       <= 1'b1;
`ifdef FETCH_SKID_BUFFER_EN
        end else if (unload) begin
            inst_PC_fetch     <= skid_pc;
            instruction_fetch <= skid_instr;
            fetch_valid       <= 1'b1;
`endif
        end else if (!stall) begin
            fetch_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_request_unit.sv
// tb_fetch_request_unit: directed checks of fetch_request_unit (skid steps follow FETCH_SKID_BUFFER_EN)
module tb_fetch_request_unit;
    localparam int DW = 32;
    localparam int AB = 20;
`ifdef FETCH_SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic [1:0]    next_PC_select_execute = 2'b00;
    logic          branch_execute = 1'b0;
    logic [AB-1:0] branch_target = '0;
    logic [AB-1:0] JAL_target = '0;
    logic [AB-1:0] JALR_target = '0;
    logic          icache_ready = 1'b1;
    logic          icache_read;
    logic [AB-1:0] icache_address;
    logic          icache_valid_in = 1'b0;
    logic [DW-1:0] icache_data = '0;
    logic [AB-1:0] inst_PC_fetch;
    logic [DW-1:0] instruction_fetch;
    logic          fetch_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    fetch_request_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .RESET_PC('0)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .stall                 (stall),
        .next_PC_select_execute(next_PC_select_execute),
        .branch_execute        (branch_execute),
        .branch_target         (branch_target),
        .JAL_target            (JAL_target),
        .JALR_target           (JALR_target),
        .icache_ready          (icache_ready),
        .icache_read           (icache_read),
        .icache_address        (icache_address),
        .icache_valid_in       (icache_valid_in),
        .icache_data           (icache_data),
        .inst_PC_fetch         (inst_PC_fetch),
        .instruction_fetch     (instruction_fetch),
        .fetch_valid           (fetch_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic respond(input logic [DW-1:0] d);
        icache_valid_in = 1'b1;
        icache_data     = d;
    endtask

    initial begin
        step(); step(); #1;
        check("rst_read", icache_read, 0);
        check("rst_addr", icache_address, 0);
        check("rst_pc", inst_PC_fetch, 0);
        check("rst_instr", instruction_fetch, 32'h13);
        check("rst_valid", fetch_valid, 0);
        reset = 1'b0; #1;
        check("first_read", icache_read, 1);
        check("first_addr", icache_address, 20'h00000);
        step();
        respond(32'hA000_0000); #1;
        check("wait_read", icache_read, 0);
        check("wait_valid", fetch_valid, 0);
        step();
        icache_valid_in = 1'b0; #1;
        check("r0_valid", fetch_valid, 1);
        check("r0_pc", inst_PC_fetch, 20'h00000);
        check("r0_instr", instruction_fetch, 32'hA000_0000);
        check("r1_read", icache_read, 1);
        check("r1_addr", icache_address, 20'h00004);
        step();
        respond(32'hA000_0004); #1;
        check("gap_valid", fetch_valid, 0);
        step();
        icache_valid_in = 1'b0; #1;
        check("r1_valid", fetch_valid, 1);
        check("r1_pc", inst_PC_fetch, 20'h00004);
        check("r2_addr", icache_address, 20'h00008);
        step();
        respond(32'hA000_0008); #1;
        step();
        icache_valid_in = 1'b0; #1;
        check("r2_pc", inst_PC_fetch, 20'h00008);
        check("r3_addr", icache_address, 20'h0000C);
        step();
        respond(32'hA000_000C); #1;
        step();
        icache_valid_in = 1'b0; #1;
        check("r4_read", icache_read, 1);
        check("r4_addr", icache_address, 20'h00010);
        step();
        respond(32'hA000_0010); #1;
        step();
        icache_valid_in = 1'b0;
        stall = 1'b1;
        icache_ready = !SKID; #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", fetch_valid, 1);
            check("hold_pc", inst_PC_fetch, 20'h00010);
            check("hold_instr", instruction_fetch, 32'hA000_0010);
            check("hold_read", icache_read, 0);
            step();
        end
        check("hold_end_valid", fetch_valid, 1);
        check("hold_end_pc", inst_PC_fetch, 20'h00010);
        stall = 1'b0;
        icache_ready = 1'b1; #1;
        check("rel_read", icache_read, 1);
        check("rel_addr", icache_address, 20'h00014);
        step();
        check("rel_clear", fetch_valid, 0);
        next_PC_select_execute = 2'b10;
        JAL_target = 20'h00200; #1;
        check("jal_read", icache_read, 0);
        step();
        next_PC_select_execute = 2'b00;
        respond(32'hA000_0014); #1;
        check("drop_read", icache_read, 0);
        check("drop_valid", fetch_valid, 0);
        step();
        icache_valid_in = 1'b0; #1;
        check("drop_discard", fetch_valid, 0);
        check("jal_req", icache_read, 1);
        check("jal_addr", icache_address, 20'h00200);
        step();
        next_PC_select_execute = 2'b01;
        branch_execute = 1'b1;
        branch_target = 20'h00300;
        respond(32'hA000_0200); #1;
        check("br_read", icache_read, 0);
        step();
        next_PC_select_execute = 2'b00;
        branch_execute = 1'b0;
        icache_valid_in = 1'b0; #1;
        check("br_valid", fetch_valid, 0);
        check("br_req", icache_read, 1);
        check("br_addr", icache_address, 20'h00300);
        step();
        reset = 1'b1; #1;
        step(); #1;
        check("mid_rst_valid", fetch_valid, 0);
        check("mid_rst_pc", inst_PC_fetch, 0);
        check("mid_rst_instr", instruction_fetch, 32'h13);
        check("mid_rst_addr", icache_address, 0);
        check("mid_rst_read", icache_read, 0);
        reset = 1'b0;
        next_PC_select_execute = 2'b01;
        branch_execute = 1'b0; #1;
        check("nt_read", icache_read, 1);
        check("nt_addr", icache_address, 0);
        next_PC_select_execute = 2'b11;
        JALR_target = 20'h00020; #1;
        check("jalr_read", icache_read, 0);
        step();
        next_PC_select_execute = 2'b00;
        stall = 1'b1; #1;
        check("jalr_req", icache_read, 1);
        check("jalr_addr", icache_address, 20'h00020);
        step();
        respond(32'hB000_0020); #1;
        step();
        icache_valid_in = 1'b0; #1;
        check("s0_valid", fetch_valid, 1);
        check("s0_pc", inst_PC_fetch, 20'h00020);
        check("s0_read", icache_read, SKID);
`ifdef FETCH_SKID_BUFFER_EN
        check("s1_addr", icache_address, 20'h00024);
        step();
        respond(32'hB000_0024); #1;
        step();
        icache_valid_in = 1'b0; #1;
        check("park_valid", fetch_valid, 1);
        check("park_pc", inst_PC_fetch, 20'h00020);
        check("park_instr", instruction_fetch, 32'hB000_0020);
        check("park_read", icache_read, 0);
        step();
        check("park_read2", icache_read, 0);
        stall = 1'b0; #1;
        check("unload_read", icache_read, 0);
        step();
        check("unload_valid", fetch_valid, 1);
        check("unload_pc", inst_PC_fetch, 20'h00024);
        check("unload_instr", instruction_fetch, 32'hB000_0024);
        check("after_read", icache_read, 1);
        check("after_addr", icache_address, 20'h00028);
`else
        stall = 1'b0; #1;
        check("ns_read", icache_read, 1);
        check("ns_addr", icache_address, 20'h00024);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
